// File: rtl/gnss_if_sample_gen_if.sv
// rtl/gnss_if_sample_gen_if.sv - control/config and sample-stream bundle for the GNSS IF sample generator
interface gnss_if_sample_gen_if #(
  parameter int NCO_W = 32
);
  logic             enable;
  logic             sample_en;
  logic             load;
  logic [5:0]       prn_sel;
  logic [NCO_W-1:0] code_fcw;
  logic [NCO_W-1:0] carr_fcw;
  logic             data_i;
  logic             sample_o;
  logic             code_o;
  logic             lo_o;
  logic             epoch_o;
  logic             bit_edge_o;
  logic [9:0]       chip_idx;

  // Controller / register side: drives config and strobes, observes the stream.
  modport master (
    output enable, sample_en, load, prn_sel, code_fcw, carr_fcw, data_i,
    input  sample_o, code_o, lo_o, epoch_o, bit_edge_o, chip_idx
  );

  // Generator side.
  modport slave (
    input  enable, sample_en, load, prn_sel, code_fcw, carr_fcw, data_i,
    output sample_o, code_o, lo_o, epoch_o, bit_edge_o, chip_idx
  );
endinterface

// File: rtl/gnss_if_sample_gen.sv
// rtl/gnss_if_sample_gen.sv - synthetic 1-bit GPS L1 C/A IF sample source (code NCO, carrier NCO, nav data)
module gnss_if_sample_gen #(
  parameter int NCO_W          = 32,
  parameter int EPOCHS_PER_BIT = 20
) (
  input logic                  wb_clk_i,
  input logic                  wb_rst_i,
  gnss_if_sample_gen_if.slave  bus
);

  localparam int EW = (EPOCHS_PER_BIT > 1) ? $clog2(EPOCHS_PER_BIT) : 1;
  localparam logic [9:0]    LAST_CHIP = 10'd1022;
  localparam logic [EW-1:0] LAST_EP   = EW'(EPOCHS_PER_BIT - 1);

  logic [NCO_W-1:0] code_acc_q, code_acc_d;
  logic [NCO_W-1:0] carr_acc_q, carr_acc_d;
  logic [NCO_W-1:0] code_fcw_q, code_fcw_d;
  logic [NCO_W-1:0] carr_fcw_q, carr_fcw_d;
  logic [5:0]       prn_q, prn_d;
  logic [10:1]      g1_q, g1_d;
  logic [10:1]      g2_q, g2_d;
  logic [9:0]       chip_q, chip_d;
  logic [EW-1:0]    ep_q, ep_d;
  logic             data_q, data_d;
  logic             epoch_q, epoch_d;
  logic             bedge_q, bedge_d;

  logic             advance;
  logic [NCO_W:0]   code_sum;
  logic [3:0]       s1, s2;
  logic             tap_ok;
  logic             code_raw;

  // G2 phase-select taps for the configured PRN; unknown PRNs leave only G1.
  always_comb begin
    s1     = 4'd1;
    s2     = 4'd1;
    tap_ok = 1'b1;
    case (prn_q)
      6'd1:  begin s1 = 4'd2; s2 = 4'd6;  end
      6'd2:  begin s1 = 4'd3; s2 = 4'd7;  end
      6'd3:  begin s1 = 4'd4; s2 = 4'd8;  end
      6'd4:  begin s1 = 4'd5; s2 = 4'd9;  end
      6'd5:  begin s1 = 4'd1; s2 = 4'd9;  end
      6'd6:  begin s1 = 4'd2; s2 = 4'd10; end
      6'd7:  begin s1 = 4'd1; s2 = 4'd8;  end
      6'd8:  begin s1 = 4'd2; s2 = 4'd9;  end
      6'd9:  begin s1 = 4'd3; s2 = 4'd10; end
      6'd10: begin s1 = 4'd2; s2 = 4'd3;  end
      6'd11: begin s1 = 4'd3; s2 = 4'd4;  end
      6'd12: begin s1 = 4'd5; s2 = 4'd6;  end
      6'd13: begin s1 = 4'd6; s2 = 4'd7;  end
      6'd14: begin s1 = 4'd7; s2 = 4'd8;  end
      6'd15: begin s1 = 4'd8; s2 = 4'd9;  end
      6'd16: begin s1 = 4'd9; s2 = 4'd10; end
      6'd17: begin s1 = 4'd1; s2 = 4'd4;  end
      6'd18: begin s1 = 4'd2; s2 = 4'd5;  end
      6'd19: begin s1 = 4'd3; s2 = 4'd6;  end
      6'd20: begin s1 = 4'd4; s2 = 4'd7;  end
      6'd21: begin s1 = 4'd5; s2 = 4'd8;  end
      6'd22: begin s1 = 4'd6; s2 = 4'd9;  end
      6'd23: begin s1 = 4'd1; s2 = 4'd3;  end
      6'd24: begin s1 = 4'd4; s2 = 4'd6;  end
      6'd25: begin s1 = 4'd5; s2 = 4'd7;  end
      6'd26: begin s1 = 4'd6; s2 = 4'd8;  end
      6'd27: begin s1 = 4'd7; s2 = 4'd9;  end
      6'd28: begin s1 = 4'd8; s2 = 4'd10; end
      6'd29: begin s1 = 4'd1; s2 = 4'd6;  end
      6'd30: begin s1 = 4'd2; s2 = 4'd7;  end
      6'd31: begin s1 = 4'd3; s2 = 4'd8;  end
      6'd32: begin s1 = 4'd4; s2 = 4'd9;  end
      default: tap_ok = 1'b0;
    endcase
  end

  // Next-state: load restarts everything, otherwise an enabled sample strobe advances both NCOs.
  always_comb begin
    code_acc_d = code_acc_q;
    carr_acc_d = carr_acc_q;
    code_fcw_d = code_fcw_q;
    carr_fcw_d = carr_fcw_q;
    prn_d      = prn_q;
    g1_d       = g1_q;
    g2_d       = g2_q;
    chip_d     = chip_q;
    ep_d       = ep_q;
    data_d     = data_q;
    epoch_d    = 1'b0;
    bedge_d    = 1'b0;
    advance    = bus.enable & bus.sample_en & ~bus.load;
    code_sum   = {1'b0, code_acc_q} + {1'b0, code_fcw_q};

    if (bus.load) begin
      prn_d      = bus.prn_sel;
      code_fcw_d = bus.code_fcw;
      carr_fcw_d = bus.carr_fcw;
      code_acc_d = '0;
      carr_acc_d = '0;
      g1_d       = '1;
      g2_d       = '1;
      chip_d     = '0;
      ep_d       = '0;
      data_d     = 1'b0;
    end else if (advance) begin
      carr_acc_d = carr_acc_q + carr_fcw_q;
      code_acc_d = code_sum[NCO_W-1:0];
      if (code_sum[NCO_W]) begin
        if (chip_q == LAST_CHIP) begin
          // End of the 1023-chip period: realign the LFSRs instead of relying on their period.
          chip_d  = '0;
          g1_d    = '1;
          g2_d    = '1;
          epoch_d = 1'b1;
          if (ep_q == LAST_EP) begin
            ep_d    = '0;
            data_d  = bus.data_i;
            bedge_d = 1'b1;
          end else begin
            ep_d = ep_q + EW'(1);
          end
        end else begin
          chip_d = chip_q + 10'd1;
          g1_d   = {g1_q[9:1], g1_q[3] ^ g1_q[10]};
          g2_d   = {g2_q[9:1], g2_q[2] ^ g2_q[3] ^ g2_q[6] ^ g2_q[8] ^ g2_q[9] ^ g2_q[10]};
        end
      end
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      code_acc_q <= '0;
      carr_acc_q <= '0;
      code_fcw_q <= '0;
      carr_fcw_q <= '0;
      prn_q      <= 6'd1;
      g1_q       <= '1;
      g2_q       <= '1;
      chip_q     <= '0;
      ep_q       <= '0;
      data_q     <= 1'b0;
      epoch_q    <= 1'b0;
      bedge_q    <= 1'b0;
    end else begin
      code_acc_q <= code_acc_d;
      carr_acc_q <= carr_acc_d;
      code_fcw_q <= code_fcw_d;
      carr_fcw_q <= carr_fcw_d;
      prn_q      <= prn_d;
      g1_q       <= g1_d;
      g2_q       <= g2_d;
      chip_q     <= chip_d;
      ep_q       <= ep_d;
      data_q     <= data_d;
      epoch_q    <= epoch_d;
      bedge_q    <= bedge_d;
    end
  end

  // The all-ones LFSR state would otherwise show code_o=1 while reset is held; gate it.
  assign code_raw       = g1_q[10] ^ (tap_ok & (g2_q[s1] ^ g2_q[s2]));
  assign bus.code_o     = code_raw & ~wb_rst_i;
  assign bus.lo_o       = carr_acc_q[NCO_W-1];
  assign bus.sample_o   = (code_raw ^ carr_acc_q[NCO_W-1] ^ data_q) & ~wb_rst_i;
  assign bus.epoch_o    = epoch_q;
  assign bus.bit_edge_o = bedge_q;
  assign bus.chip_idx   = chip_q;

endmodule
